// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, BRAM read issue, 1-entry skid, EX redirect.
// One read is inflight at most, so a single skid entry covers a stall.
module fetch_unit #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           id_instr,
  output logic [31:0]           id_pc,
  output logic                  id_valid
);

  typedef enum logic {
    EMPTY,
    FULL
  } skid_state_t;

  skid_state_t state, state_next;

  logic [31:0] fetch_pc;
  logic        req_v;
  logic [31:0] req_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_v;
  logic        issue;
  logic [31:0] issue_pc;

  assign skid_v = (state == FULL);

  always_comb begin
    issue      = 1'b0;
    issue_pc   = fetch_pc;
    state_next = state;
    if (redirect) issue_pc = redirect_pc & 32'hFFFF_FFFC;
    if (rst) begin
      state_next = EMPTY;
    end else if (redirect) begin
      issue      = 1'b1;
      state_next = EMPTY;
    end else begin
      issue = !stall && !skid_v;
      unique case (state)
        EMPTY: if (req_v && stall) state_next = FULL;
        FULL:  if (!stall) state_next = EMPTY;
        default: state_next = EMPTY;
      endcase
    end
  end

  assign imem_en   = issue;
  assign imem_addr = issue_pc[ADDR_WIDTH+1:2];

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      req_v      <= 1'b0;
      req_pc     <= 32'h0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      id_instr   <= 32'h0;
      id_pc      <= 32'h0;
      id_valid   <= 1'b0;
    end else begin
      req_v <= issue;
      if (issue) begin
        req_pc   <= issue_pc;
        fetch_pc <= issue_pc + 32'd4;
      end
      // redirect kills the word returning this cycle and any skid entry
      if (redirect) begin
        id_valid <= 1'b0;
      end else if (skid_v) begin
        if (!stall) begin
          id_instr <= skid_instr;
          id_pc    <= skid_pc;
          id_valid <= 1'b1;
        end
      end else if (req_v) begin
        if (stall) begin
          skid_instr <= imem_rdata;
          skid_pc    <= req_pc;
        end else begin
          id_instr <= imem_rdata;
          id_pc    <= req_pc;
          id_valid <= 1'b1;
        end
      end else if (!stall) begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit against a program-order PC model.
// Directed phases cover startup, stall, redirect, skid flush, wrap, reset.
module tb_fetch_unit;

  localparam int          AW  = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic          id_valid;

  fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1<<AW];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000 + i;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // program-order model: PCs decode should consume next
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = RPC;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic drive(input bit s, input bit r, input logic [31:0] rp,
                       input bit rs);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    rst         = rs;
    if (rs) begin
      exp_q.delete();
      model_pc = RPC;
    end else if (r) begin
      exp_q.delete();
      model_pc = {rp[31:2], 2'b00};
    end
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  // monitor: stream check plus timing rules
  bit          p_rst = 1'b1, pp_rst = 1'b1, ppp_rst = 1'b1;
  bit          p_redir = 1'b0, pp_redir = 1'b0;
  bit          p_stall = 1'b0;
  bit          p_quiet = 1'b0, pp_quiet = 1'b0;
  logic [31:0] p_tgt = 32'h0, pp_tgt = 32'h0;
  logic [31:0] p_pc = 32'h0, p_instr = 32'h0;
  bit          p_valid = 1'b0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) chk(imem_en == 1'b0, "imem_en_in_rst", {31'b0, imem_en}, 32'h0);
    if (p_rst) begin
      chk(id_valid == 1'b0, "rst_valid", {31'b0, id_valid}, 32'h0);
      chk(id_pc == 32'h0, "rst_pc", id_pc, 32'h0);
      chk(id_instr == 32'h0, "rst_instr", id_instr, 32'h0);
    end else if (p_redir) begin
      chk(id_valid == 1'b0, "redir_bubble", {31'b0, id_valid}, 32'h0);
    end else if (p_stall) begin
      chk(id_valid == p_valid && id_pc == p_pc && id_instr == p_instr,
          "stall_hold", id_pc, p_pc);
    end
    if (ppp_rst && !pp_rst && pp_quiet && p_quiet) begin
      chk(id_valid == 1'b1, "startup_valid", {31'b0, id_valid}, 32'h1);
      chk(id_pc == RPC, "startup_pc", id_pc, RPC);
    end
    if (pp_redir && !pp_rst && p_quiet) begin
      e = pp_tgt & 32'hFFFF_FFFC;
      chk(id_valid == 1'b1, "redir_valid", {31'b0, id_valid}, 32'h1);
      chk(id_pc == e, "redir_pc", id_pc, e);
    end
    if (id_valid && !stall && !redirect && !rst) begin
      consumed++;
      if (exp_q.size() == 0) begin
        chk(1'b0, "stream_empty", id_pc, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk(id_pc == e, "stream_pc", id_pc, e);
        chk(id_instr == mem[e[AW+1:2]], "stream_instr", id_instr,
            mem[e[AW+1:2]]);
      end
    end
    ppp_rst  = pp_rst;
    pp_rst   = p_rst;
    p_rst    = rst;
    pp_redir = p_redir;
    p_redir  = redirect;
    pp_tgt   = p_tgt;
    p_tgt    = redirect_pc;
    p_stall  = stall;
    pp_quiet = p_quiet;
    p_quiet  = !rst && !redirect && !stall;
    p_pc     = id_pc;
    p_instr  = id_instr;
    p_valid  = id_valid;
  end

  initial begin
    bit seen;
    drive(0, 0, 32'h0, 1);
    repeat (3) tick();
    drive(0, 0, 32'h0, 0);

    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (id_valid && id_pc == 32'h8) seen = 1'b1;
    end
    chk(seen, "reach_pc8", id_pc, 32'h8);
    drive(1, 0, 32'h0, 0);
    repeat (3) tick();
    drive(0, 0, 32'h0, 0);
    repeat (10) tick();

    drive(0, 1, 32'h40, 0);
    tick();
    drive(0, 0, 32'h0, 0);
    repeat (8) tick();

    drive(1, 0, 32'h0, 0);
    repeat (2) tick();
    drive(1, 1, 32'h103, 0);
    tick();
    drive(0, 0, 32'h0, 0);
    repeat (6) tick();

    drive(0, 1, 32'h3C, 0);
    tick();
    drive(0, 0, 32'h0, 0);
    repeat (6) tick();

    drive(0, 1, 32'hFFFF_FFF8, 0);
    tick();
    drive(0, 0, 32'h0, 0);
    repeat (6) tick();

    drive(1, 0, 32'h0, 0);
    repeat (2) tick();
    drive(1, 0, 32'h0, 1);
    tick();
    drive(0, 0, 32'h0, 0);
    repeat (8) tick();

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 10) < 3, ($urandom % 25) == 0, $urandom,
            ($urandom % 150) == 0);
      tick();
    end
    drive(0, 0, 32'h0, 0);
    repeat (4) tick();

    chk(consumed > 1000, "progress", consumed, 32'd1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 2nd core. Keeps the architectural fetch PC and issues word reads to the 1-cycle-latency instruction BRAM. Presents one instruction per cycle, with its PC and a valid bit, on the IF/ID outputs; the instruction drives the Decoder's `op`/`funct3` fields. Handles decode-side stalls with a 1-entry skid buffer and branch/jump redirects from EX with a flush of everything in flight.

## Interface
- `ADDR_WIDTH`, 14: instruction BRAM word-address width.
- `RESET_PC`, 32'h0: fetch PC loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode cannot accept; IF/ID outputs must hold.
- `redirect`  in  1  taken branch/jump resolved in EX.
- `redirect_pc`  in  32  target byte address; bits [1:0] ignored.
- `imem_en`  out  1  BRAM read enable (combinational).
- `imem_addr`  out  ADDR_WIDTH  BRAM word address (combinational).
- `imem_rdata`  in  32  BRAM data; valid the cycle after an `imem_en` cycle.
- `id_instr`  out  32  instruction to decode (registered).
- `id_pc`  out  32  byte PC of `id_instr` (registered).
- `id_valid`  out  1  `id_instr`/`id_pc` are meaningful (registered).

## Operation
- **State:**
  - `fetch_pc` (32): next PC to request.
  - Inflight tag: `req_v`, `req_pc`. This is the read issued last cycle.
  - Skid: `skid_v`, `skid_instr`, `skid_pc`.
  - Output regs: `id_*`.
- **Issue, combinational, in priority order:**
  - `rst`: `imem_en=0`.
  - `redirect`: `imem_en=1`, `imem_addr=redirect_pc[ADDR_WIDTH+1:2]`.
  - `!stall && !skid_v`: `imem_en=1`, `imem_addr=fetch_pc[ADDR_WIDTH+1:2]`.
  - Otherwise: `imem_en=0`.
- **Issue bookkeeping:**
  - On an issue, `req_v<=1`, `req_pc<=` the issued PC (low 2 bits zeroed), and `fetch_pc<=` the issued PC + 4.
  - With no issue, `req_v<=0` and `fetch_pc` holds.
- **Return, when `req_v=1`:**
  - If `stall=0` and `skid_v=0`: `id_instr<=imem_rdata`, `id_pc<=req_pc`, `id_valid<=1`.
  - If `stall=1`: the word goes to skid, `skid_v<=1`; `id_*` hold.
- **Skid FSM:**
  - EMPTY→FULL on a return under stall.
  - FULL→EMPTY on the first cycle with `stall=0`: `id_*<=skid`, `id_valid<=1`.
  - No issue while FULL. At most one read is ever inflight, so skid never overflows.
- **No data, `stall=0`:** if neither `req_v` nor `skid_v` is set, `id_valid<=0`.
- **Redirect:**
  - Overrides `stall`.
  - `id_valid<=0`, `skid_v<=0`.
  - The return from the previous request is discarded.
  - A new read at `redirect_pc` is issued the same cycle.
- **Arithmetic:**
  - `fetch_pc` wraps modulo 2^32.
  - `imem_addr` wraps modulo 2^ADDR_WIDTH words, with no error flag.
- **Priority:** `rst` > `redirect` > `stall`.

## Timing
- **Reset values:**
  - `fetch_pc=RESET_PC`; `req_v=0`; `skid_v=0`.
  - `id_valid=0`, `id_instr=0`, `id_pc=0`.
  - `imem_en=0` while `rst=1`.
- **Reset mid-operation:** inflight and skid contents are dropped; the next cycle behaves as the first post-reset cycle.
- **Startup:** first issue is in cycle R+1 after `rst` deasserts in cycle R. `id_valid=1` with `id_pc=RESET_PC` in cycle R+3.
- **Latency:** issue in t, data in t+1, visible on `id_*` in t+2.
- **Throughput:** 1 instruction/cycle with `stall=0`.
- **Redirect:**
  - Asserted in cycle t: `id_valid=0` in t+1.
  - `id_pc=redirect_pc` with `id_valid=1` in t+2.
  - Penalty: 2 bubble cycles.
- **Stall of k cycles starting at t:**
  - `id_*` constant through t..t+k-1.
  - Skid delivers in t+k+1 (first cycle after `stall` falls); the next issue happens in that same cycle.
  - No instruction is lost or duplicated.

## Test plan
- **Reset and stream:** release `rst`; BRAM holds word i = 32'h1000+i. Expect `id_valid` in cycle R+3 with `id_pc` sequence 0,4,8,… and `id_instr` 32'h1000,32'h1001,… one per cycle.
- **Stall 3 cycles mid-stream:** raise `stall` while `id_pc=8`. `id_pc` stays 8 for 3 cycles, then 12,16,… with no gap beyond the stall and no duplicate.
- **Redirect:** pulse `redirect` with `redirect_pc=32'h40` while streaming. Expect `id_valid=0` next cycle, then `id_pc=32'h40` and `id_instr` = word 16. The instruction that was inflight never appears.
- **Redirect during stall with skid full:** `stall=1`, `redirect=1`, `redirect_pc=32'h103` in the same cycle. Skid is dropped, `id_valid=0`, and `id_pc=32'h100` appears 2 cycles later.
- **Wrap:** `ADDR_WIDTH=4`, redirect to 32'h3C. Expect `id_pc` 32'h3C, 32'h40 with `id_instr` = words 15, 0.
- **Reset during stall with skid full:** all valids clear next cycle, and the stream restarts from `RESET_PC`.
